// File: rtl/framebuffer_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_port_arbiter
// Description : Round-robin share of the framebuffer index-RAM port between
//               the SPI GPU path (A), the soft-CPU path (B) and a fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_port_arbiter #(
  parameter int ADDR_W            = 17,
  parameter int DATA_W            = 8,
  parameter int FB_DEPTH          = 76800,
  parameter int BLANK_ONLY_WRITES = 0
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              hblank,
  input  logic              vblank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              fb_wren,
  input  logic [DATA_W-1:0] fb_rdata
);

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  localparam logic [1:0]        c_ptr_a    = 2'd0;
  localparam logic [1:0]        c_ptr_b    = 2'd1;
  localparam logic [1:0]        c_ptr_f    = 2'd2;
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W:0]   c_last     = (ADDR_W+1)'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_len_one  = (ADDR_W+1)'(1);

  fill_state_t       r_state;
  fill_state_t       w_state_nxt;
  logic [1:0]        r_rr_ptr;
  logic [ADDR_W-1:0] r_fill_cur;
  logic [ADDR_W:0]   r_fill_rem;
  logic [DATA_W-1:0] r_fill_color;
  logic              r_rd1_valid;
  logic              r_rd1_sel_b;
  logic              r_rd2_valid;
  logic              r_rd2_sel_b;
  logic              w_wr_ok;
  logic              w_elig_a;
  logic              w_elig_b;
  logic              w_elig_f;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_gnt_f;
  logic [ADDR_W-1:0] w_fill_base;
  logic [ADDR_W-1:0] w_fill_next;

  assign w_wr_ok  = (BLANK_ONLY_WRITES == 0) || hblank || vblank;
  assign w_elig_a = a_valid & (~a_we | w_wr_ok);
  assign w_elig_b = b_valid & (~b_we | w_wr_ok);
  assign w_elig_f = (r_state == FILL_RUN) & w_wr_ok;

  // Search begins at r_rr_ptr, which always names the requester after the last grant.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    w_gnt_f = 1'b0;
    if (reset_n) begin
      case (r_rr_ptr)
        c_ptr_b: begin
          if (w_elig_b)      w_gnt_b = 1'b1;
          else if (w_elig_f) w_gnt_f = 1'b1;
          else if (w_elig_a) w_gnt_a = 1'b1;
        end
        c_ptr_f: begin
          if (w_elig_f)      w_gnt_f = 1'b1;
          else if (w_elig_a) w_gnt_a = 1'b1;
          else if (w_elig_b) w_gnt_b = 1'b1;
        end
        default: begin
          if (w_elig_a)      w_gnt_a = 1'b1;
          else if (w_elig_b) w_gnt_b = 1'b1;
          else if (w_elig_f) w_gnt_f = 1'b1;
        end
      endcase
    end
  end

  assign a_ready   = w_gnt_a;
  assign b_ready   = w_gnt_b;
  assign fill_busy = (r_state != FILL_IDLE);
  assign fill_done = (r_state == FILL_DONE);

  assign w_fill_base = ({1'b0, fill_base} >= c_depth) ? ADDR_W'({1'b0, fill_base} - c_depth)
                                                      : fill_base;
  assign w_fill_next = ({1'b0, r_fill_cur} == c_last) ? '0 : r_fill_cur + c_addr_one;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL_IDLE: if (fill_start) w_state_nxt = (fill_len == '0) ? FILL_DONE : FILL_RUN;
      FILL_RUN:  if (w_gnt_f && (r_fill_rem == c_len_one)) w_state_nxt = FILL_DONE;
      FILL_DONE: w_state_nxt = FILL_IDLE;
      default:   w_state_nxt = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FILL_IDLE;
      r_rr_ptr     <= c_ptr_a;
      r_fill_cur   <= '0;
      r_fill_rem   <= '0;
      r_fill_color <= '0;
      fb_addr      <= '0;
      fb_wdata     <= '0;
      fb_wren      <= 1'b0;
      r_rd1_valid  <= 1'b0;
      r_rd1_sel_b  <= 1'b0;
      r_rd2_valid  <= 1'b0;
      r_rd2_sel_b  <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == FILL_IDLE) && fill_start) begin
        r_fill_cur   <= w_fill_base;
        r_fill_rem   <= fill_len;
        r_fill_color <= fill_color;
      end else if (w_gnt_f) begin
        r_fill_cur <= w_fill_next;
        r_fill_rem <= r_fill_rem - c_len_one;
      end

      if (w_gnt_a)      r_rr_ptr <= c_ptr_b;
      else if (w_gnt_b) r_rr_ptr <= c_ptr_f;
      else if (w_gnt_f) r_rr_ptr <= c_ptr_a;

      // fb_addr/fb_wdata hold through idle cycles; only fb_wren drops.
      if (w_gnt_a) begin
        fb_addr  <= a_addr;
        fb_wdata <= a_wdata;
      end else if (w_gnt_b) begin
        fb_addr  <= b_addr;
        fb_wdata <= b_wdata;
      end else if (w_gnt_f) begin
        fb_addr  <= r_fill_cur;
        fb_wdata <= r_fill_color;
      end
      fb_wren <= (w_gnt_a & a_we) | (w_gnt_b & b_we) | w_gnt_f;

      r_rd1_valid <= (w_gnt_a & ~a_we) | (w_gnt_b & ~b_we);
      r_rd1_sel_b <= w_gnt_b;
      r_rd2_valid <= r_rd1_valid;
      r_rd2_sel_b <= r_rd1_sel_b;
      a_rvalid    <= r_rd2_valid & ~r_rd2_sel_b;
      b_rvalid    <= r_rd2_valid & r_rd2_sel_b;
      if (r_rd2_valid && !r_rd2_sel_b) a_rdata <= fb_rdata;
      if (r_rd2_valid && r_rd2_sel_b)  b_rdata <= fb_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_port_arbiter
// Description : Scoreboard bench for framebuffer_port_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_port_arbiter;

  localparam int DEPTH = 76800;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [16:0] a_addr = 0, b_addr = 0;
  logic [7:0]  a_wdata = 0, b_wdata = 0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        fill_start = 0;
  logic [16:0] fill_base = 0;
  logic [17:0] fill_len = 0;
  logic [7:0]  fill_color = 0;
  logic        fill_busy, fill_done;
  logic        hblank = 0, vblank = 0;
  logic [16:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_wren;
  logic [7:0]  fb_rdata;

  logic        d2_a_valid = 0, d2_a_we = 0, d2_b_valid = 0, d2_b_we = 0;
  logic [16:0] d2_a_addr = 0, d2_b_addr = 0;
  logic [7:0]  d2_a_wdata = 0, d2_b_wdata = 0;
  logic        d2_a_ready, d2_b_ready, d2_a_rvalid, d2_b_rvalid;
  logic [7:0]  d2_a_rdata, d2_b_rdata;
  logic        d2_fill_start = 0;
  logic [16:0] d2_fill_base = 0;
  logic [17:0] d2_fill_len = 0;
  logic [7:0]  d2_fill_color = 0;
  logic        d2_fill_busy, d2_fill_done;
  logic        d2_hblank = 0, d2_vblank = 0;
  logic [16:0] d2_fb_addr;
  logic [7:0]  d2_fb_wdata;
  logic        d2_fb_wren;
  logic [7:0]  d2_fb_rdata;

  framebuffer_port_arbiter dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .hblank(hblank), .vblank(vblank),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_wren(fb_wren), .fb_rdata(fb_rdata)
  );

  framebuffer_port_arbiter #(.BLANK_ONLY_WRITES(1)) dut_blank (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .a_valid(d2_a_valid), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
    .a_ready(d2_a_ready), .a_rvalid(d2_a_rvalid), .a_rdata(d2_a_rdata),
    .b_valid(d2_b_valid), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata),
    .b_ready(d2_b_ready), .b_rvalid(d2_b_rvalid), .b_rdata(d2_b_rdata),
    .fill_start(d2_fill_start), .fill_base(d2_fill_base), .fill_len(d2_fill_len),
    .fill_color(d2_fill_color), .fill_busy(d2_fill_busy), .fill_done(d2_fill_done),
    .hblank(d2_hblank), .vblank(d2_vblank),
    .fb_addr(d2_fb_addr), .fb_wdata(d2_fb_wdata), .fb_wren(d2_fb_wren), .fb_rdata(d2_fb_rdata)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  // Framebuffer model: registered read, one cycle latency, read-before-write.
  logic [7:0] ram [0:DEPTH-1];
  bit         ram_init = 1'b0;
  always @(posedge clk_pixel) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i) ^ 8'hC3;
      ram[16]  = 8'h5A;
      ram_init = 1'b1;
    end
    if (fb_wren) ram[fb_addr] <= fb_wdata;
    fb_rdata    <= ram[fb_addr];
    d2_fb_rdata <= d2_fb_addr[7:0];
  end

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_t;

  logic [7:0] exp_mem [0:DEPTH-1];
  rd_t        qa[$];
  rd_t        qb[$];
  int         vectors = 0;
  int         fails   = 0;

  task automatic monitor();
    rd_t e;
    forever begin
      @(negedge clk_pixel);
      if (reset_n) begin
        if (a_valid && a_ready) begin
          if (a_we) exp_mem[a_addr] = a_wdata;
          else qa.push_back('{exp_mem[a_addr], cyc});
        end
        if (b_valid && b_ready) begin
          if (b_we) exp_mem[b_addr] = b_wdata;
          else qb.push_back('{exp_mem[b_addr], cyc});
        end
        if (a_rvalid) begin
          vectors++;
          if (qa.size() == 0) begin
            fails++;
            $display("FAIL a_rvalid_unexpected: got rvalid=1 expected 0 at cycle %0d", cyc);
          end else begin
            e = qa.pop_front();
            if (a_rdata !== e.data || cyc != e.cyc + 3) begin
              fails++;
              $display("FAIL a_read_result: got %h @cyc %0d expected %h @cyc %0d",
                       a_rdata, cyc, e.data, e.cyc + 3);
            end
          end
        end
        if (b_rvalid) begin
          vectors++;
          if (qb.size() == 0) begin
            fails++;
            $display("FAIL b_rvalid_unexpected: got rvalid=1 expected 0 at cycle %0d", cyc);
          end else begin
            e = qb.pop_front();
            if (b_rdata !== e.data || cyc != e.cyc + 3) begin
              fails++;
              $display("FAIL b_read_result: got %h @cyc %0d expected %h @cyc %0d",
                       b_rdata, cyc, e.data, e.cyc + 3);
            end
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_we = 0; b_valid = 0; b_we = 0; fill_start = 0;
    hblank = 0; vblank = 0;
    d2_a_valid = 0; d2_a_we = 0; d2_b_valid = 0; d2_b_we = 0;
    d2_hblank = 0; d2_vblank = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1;
  endtask

  task automatic port_read(input bit use_b, input logic [16:0] addr);
    bit got = 0;
    if (use_b) begin b_valid = 1; b_we = 0; b_addr = addr; end
    else       begin a_valid = 1; a_we = 0; a_addr = addr; end
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk_pixel);
      if (use_b ? b_ready : a_ready) got = 1;
      @(posedge clk_pixel); #1;
    end
    a_valid = 0; b_valid = 0;
    vectors++;
    if (!got) begin
      fails++;
      $display("FAIL read_accept_timeout: got ready=0 expected 1 within 8 cycles");
    end
    repeat (4) @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    a_valid = 1; a_we = 0; a_addr = 17'd5;
    @(negedge clk_pixel);
    vectors += 4;
    if (a_ready !== 1'b0) begin fails++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    if (fb_wren !== 1'b0 || fb_addr !== '0 || fb_wdata !== '0) begin
      fails++; $display("FAIL reset_fb: got wren=%b addr=%h data=%h expected 0/0/0", fb_wren, fb_addr, fb_wdata);
    end
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== '0 || b_rdata !== '0) begin
      fails++; $display("FAIL reset_read_side: got %b %b %h %h expected all 0", a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      fails++; $display("FAIL reset_fill: got busy=%b done=%b expected 0/0", fill_busy, fill_done);
    end
    a_valid = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(posedge clk_pixel); #1;
    a_valid = 1; a_we = 0; a_addr = 17'h00010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_pixel);
      vectors++;
      if (k == 0 && a_ready !== 1'b1) begin fails++; $display("FAIL read_ready: got %b expected 1", a_ready); end
      if (k == 1 && (fb_addr !== 17'h10 || fb_wren !== 1'b0)) begin
        fails++; $display("FAIL read_fb_issue: got addr=%h wren=%b expected 00010/0", fb_addr, fb_wren);
      end
      if (k != 3 && k != 0 && a_rvalid !== 1'b0) begin fails++; $display("FAIL read_rvalid_early: got %b expected 0 (k=%0d)", a_rvalid, k); end
      if (k == 3 && (a_rvalid !== 1'b1 || a_rdata !== 8'h5A || b_rvalid !== 1'b0)) begin
        fails++; $display("FAIL read_result: got rv=%b data=%h brv=%b expected 1/5a/0", a_rvalid, a_rdata, b_rvalid);
      end
      @(posedge clk_pixel); #1;
      a_valid = 0;
    end
  endtask

  task automatic test_alternating_writes();
    bit exp_a;
    do_reset();
    @(posedge clk_pixel); #1;
    a_valid = 1; a_we = 1; a_addr = 17'd1; a_wdata = 8'h11;
    b_valid = 1; b_we = 1; b_addr = 17'd2; b_wdata = 8'h22;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_pixel);
      exp_a = (k % 2 == 0);
      vectors++;
      if (a_ready !== exp_a || b_ready !== !exp_a) begin
        fails++; $display("FAIL alt_grant k=%0d: got a=%b b=%b expected a=%b b=%b", k, a_ready, b_ready, exp_a, !exp_a);
      end
      if (k >= 1) begin
        vectors++;
        if (fb_wren !== 1'b1 || fb_addr !== ((k % 2 == 1) ? 17'd1 : 17'd2) ||
            fb_wdata !== ((k % 2 == 1) ? 8'h11 : 8'h22)) begin
          fails++; $display("FAIL alt_fb k=%0d: got wren=%b addr=%h data=%h", k, fb_wren, fb_addr, fb_wdata);
        end
      end
      @(posedge clk_pixel); #1;
    end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_fill_wrap();
    int ea;
    bit exp_busy, exp_done, exp_wren;
    do_reset();
    @(posedge clk_pixel); #1;
    fill_start = 1; fill_base = 17'd76798; fill_len = 18'd4; fill_color = 8'h07;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_pixel);
      exp_busy = (k >= 1 && k <= 5);
      exp_done = (k == 5);
      exp_wren = (k >= 2 && k <= 5);
      vectors++;
      if (fill_busy !== exp_busy || fill_done !== exp_done || fb_wren !== exp_wren) begin
        fails++; $display("FAIL fill_wrap_ctl k=%0d: got busy=%b done=%b wren=%b expected %b/%b/%b",
                          k, fill_busy, fill_done, fb_wren, exp_busy, exp_done, exp_wren);
      end
      if (exp_wren) begin
        ea = (76798 + k - 2) % DEPTH;
        vectors++;
        if (fb_addr !== ea[16:0] || fb_wdata !== 8'h07) begin
          fails++; $display("FAIL fill_wrap_addr k=%0d: got %h/%h expected %h/07", k, fb_addr, fb_wdata, ea[16:0]);
        end
      end
      @(posedge clk_pixel); #1;
      fill_start = 0;
    end
    for (int j = 0; j < 4; j++) exp_mem[(76798 + j) % DEPTH] = 8'h07;
    port_read(0, 17'd76799);
    port_read(0, 17'd0);
    port_read(1, 17'd2);
  endtask

  task automatic test_fill_contention();
    bit exp_a, exp_b;
    do_reset();
    @(posedge clk_pixel); #1;
    a_valid = 1; a_we = 1; a_addr = 17'd200; a_wdata = 8'h44;
    b_valid = 1; b_we = 1; b_addr = 17'd201; b_wdata = 8'h55;
    fill_start = 1; fill_base = 17'd100; fill_len = 18'd6; fill_color = 8'h33;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk_pixel);
      if (k <= 17) begin exp_a = (k % 3 == 0); exp_b = (k % 3 == 1); end
      else begin exp_a = ((k - 18) % 2 == 0); exp_b = !exp_a; end
      vectors += 2;
      if (a_ready !== exp_a || b_ready !== exp_b) begin
        fails++; $display("FAIL contention_grant k=%0d: got a=%b b=%b expected a=%b b=%b", k, a_ready, b_ready, exp_a, exp_b);
      end
      if (fill_done !== (k == 18) || fill_busy !== (k >= 1 && k <= 18)) begin
        fails++; $display("FAIL contention_fill k=%0d: got done=%b busy=%b", k, fill_done, fill_busy);
      end
      if (k >= 3 && k <= 18 && (k % 3 == 0)) begin
        vectors++;
        if (fb_wren !== 1'b1 || fb_addr !== 17'(100 + (k - 3) / 3) || fb_wdata !== 8'h33) begin
          fails++; $display("FAIL contention_fill_write k=%0d: got wren=%b addr=%h data=%h expected 1/%h/33",
                            k, fb_wren, fb_addr, fb_wdata, 17'(100 + (k - 3) / 3));
        end
      end
      @(posedge clk_pixel); #1;
      fill_start = 0;
    end
    a_valid = 0; b_valid = 0;
    for (int j = 100; j < 106; j++) exp_mem[j] = 8'h33;
    port_read(1, 17'd103);
    port_read(0, 17'd200);
    port_read(1, 17'd106);
  endtask

  task automatic test_blank_gating();
    bit got = 0;
    do_reset();
    @(posedge clk_pixel); #1;
    d2_a_valid = 1; d2_a_we = 1; d2_a_addr = 17'd5; d2_a_wdata = 8'h99;
    d2_b_valid = 1; d2_b_we = 0; d2_b_addr = 17'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pixel);
      vectors++;
      if (d2_a_ready !== 1'b0 || d2_b_ready !== 1'b1 || (k >= 1 && d2_fb_wren !== 1'b0)) begin
        fails++; $display("FAIL blank_gate k=%0d: got a=%b b=%b wren=%b expected 0/1/0", k, d2_a_ready, d2_b_ready, d2_fb_wren);
      end
      @(posedge clk_pixel); #1;
    end
    d2_vblank = 1;
    for (int t = 0; t < 2 && !got; t++) begin
      @(negedge clk_pixel);
      if (d2_a_ready) got = 1;
      @(posedge clk_pixel); #1;
    end
    vectors++;
    if (!got) begin fails++; $display("FAIL blank_open: got a_ready=0 expected 1 within 2 cycles"); end
    @(negedge clk_pixel);
    vectors++;
    if (d2_fb_wren !== 1'b1 || d2_fb_addr !== 17'd5 || d2_fb_wdata !== 8'h99) begin
      fails++; $display("FAIL blank_write: got wren=%b addr=%h data=%h expected 1/00005/99", d2_fb_wren, d2_fb_addr, d2_fb_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_fill_zero();
    do_reset();
    @(posedge clk_pixel); #1;
    fill_start = 1; fill_base = 17'd10; fill_len = 18'd0; fill_color = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pixel);
      vectors++;
      if (fill_done !== (k == 1) || fill_busy !== (k == 1) || fb_wren !== 1'b0) begin
        fails++; $display("FAIL fill_zero k=%0d: got done=%b busy=%b wren=%b expected %b/%b/0",
                          k, fill_done, fill_busy, fb_wren, k == 1, k == 1);
      end
      @(posedge clk_pixel); #1;
      fill_start = 0;
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen_done = 0, seen_rv = 0, seen_wr = 0;
    do_reset();
    @(posedge clk_pixel); #1;
    fill_start = 1; fill_base = 17'd0; fill_len = 18'd100; fill_color = 8'h66;
    @(posedge clk_pixel); #1;
    fill_start = 0;
    @(posedge clk_pixel); #1;
    @(posedge clk_pixel); #1;
    a_valid = 1; a_we = 0; a_addr = 17'd16;
    @(negedge clk_pixel);
    vectors++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL midfill_read_ready: got %b expected 1", a_ready); end
    @(posedge clk_pixel); #1;
    a_valid = 0;
    #2 reset_n = 0;
    #1;
    vectors += 2;
    if (fb_wren !== 1'b0 || fb_addr !== '0 || fb_wdata !== '0) begin
      fails++; $display("FAIL midfill_reset_fb: got wren=%b addr=%h data=%h expected 0/0/0", fb_wren, fb_addr, fb_wdata);
    end
    if (fill_busy !== 1'b0 || fill_done !== 1'b0 || a_rvalid !== 1'b0) begin
      fails++; $display("FAIL midfill_reset_ctl: got busy=%b done=%b rv=%b expected 0/0/0", fill_busy, fill_done, a_rvalid);
    end
    qa.delete();
    exp_mem[0] = 8'h66;
    exp_mem[1] = 8'h66;
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk_pixel);
      if (fill_done) seen_done = 1;
      if (a_rvalid)  seen_rv = 1;
      if (fb_wren)   seen_wr = 1;
    end
    vectors += 3;
    if (seen_done) begin fails++; $display("FAIL midfill_done: got fill_done=1 expected never"); end
    if (seen_rv)   begin fails++; $display("FAIL midfill_rvalid: got a_rvalid=1 expected never"); end
    if (seen_wr)   begin fails++; $display("FAIL midfill_wren: got fb_wren=1 expected never"); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'(i) ^ 8'hC3;
    exp_mem[16] = 8'h5A;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_alternating_writes();
    test_fill_wrap();
    test_fill_contention();
    test_blank_gating();
    test_fill_zero();
    test_reset_mid_fill();
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++; $display("FAIL pending_reads: got %0d/%0d outstanding expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
